// File: rtl/rc_pkg.sv
// rc_pkg: shared types and helpers for the ICAP bitstream streamer.
//   rc_state_t      - streamer FSM states
//   width_ratio()   - ICAP words per input beat
//   idx_bits()      - width of a word-index counter for a given ratio (min 1)
//   bitswap_bytes() - reverse bit order inside each byte of a word up to 64 bits
package rc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    STREAM,
    POST,
    DONE
  } rc_state_t;

  localparam int BITSWAP_MAX_W = 64;

  function automatic int width_ratio(input int in_w, input int icap_w);
    return in_w / icap_w;
  endfunction

  function automatic int idx_bits(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic logic [BITSWAP_MAX_W-1:0] bitswap_bytes(input logic [BITSWAP_MAX_W-1:0] w);
    logic [BITSWAP_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BITSWAP_MAX_W / 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        r[8*i + j] = w[8*i + 7 - j];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rc_sync_fifo.sv
// rc_sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst      - clock, async active-high reset (pointers only)
//   flush         - synchronous empty; wins over a push in the same cycle
//   push, din     - write port, ignored when full
//   pop, dout     - read port; dout shows the head entry while !empty
//   full, empty   - status
module rc_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; a write during flush lands in a slot that is
  // immediately considered free again.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rc_icap_streamer.sv
// rc_icap_streamer: buffers wide bitstream beats, splits them into ICAP words
// (lowest word first, optional per-byte bit reversal) and strobes them into
// ICAPE2, with decouple held high for a guard interval around the transfer.
//   AXI_aclk, AXI_areset         - clock, async active-high reset
//   start, bs_length, bitswap_en - transfer request (length in ICAP words)
//   abort                        - terminate a running transfer
//   s_tdata, s_tvalid, s_tready  - beat input stream
//   icape2_data_out, icape2_strb - registered ICAP word and strobe
//   decouple, busy, done         - sequencing status
//   aborted, err_length          - sticky status, cleared by the next start
//
// state  | meaning
// IDLE   | waiting for start
// PRE    | decouple high, guard before first word, buffering beats
// STREAM | emitting one word per cycle whenever the buffer has data
// POST   | decouple still high, guard after last word
// DONE   | one-cycle completion pulse
module rc_icap_streamer
  import rc_pkg::*;
#(
  parameter int IN_DATA_WIDTH  = 64,
  parameter int ICAP_WIDTH     = 32,
  parameter int BS_LENGTH_BITS = 24,
  parameter int FIFO_DEPTH     = 16,
  parameter int DECOUPLE_GUARD = 8
) (
  input  logic                      AXI_aclk,
  input  logic                      AXI_areset,
  input  logic                      start,
  input  logic [BS_LENGTH_BITS-1:0] bs_length,
  input  logic                      bitswap_en,
  input  logic                      abort,
  input  logic [IN_DATA_WIDTH-1:0]  s_tdata,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  output logic [ICAP_WIDTH-1:0]     icape2_data_out,
  output logic                      icape2_strb,
  output logic                      decouple,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted,
  output logic                      err_length
);

  localparam int R     = width_ratio(IN_DATA_WIDTH, ICAP_WIDTH);
  localparam int LOG2R = $clog2(R);
  localparam int IW    = idx_bits(R);
  localparam int GW    = $clog2(DECOUPLE_GUARD + 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(R - 1);
  // The normal path enters POST in the cycle of the last strobe, the abort
  // path one cycle after it, so abort loads one less to keep the post-strobe
  // decouple time identical.
  localparam logic [GW-1:0] GUARD_FULL = GW'(DECOUPLE_GUARD);
  localparam logic [GW-1:0] GUARD_LESS = GW'(DECOUPLE_GUARD - 1);

  rc_state_t                 state_q, state_d;
  logic [GW-1:0]             guard_q, guard_d;
  logic [BS_LENGTH_BITS-1:0] words_left_q, words_left_d;
  logic [BS_LENGTH_BITS-1:0] beats_left_q, beats_left_d;
  logic [IW-1:0]             word_idx_q, word_idx_d;
  logic                      swap_q, swap_d;
  logic                      strb_q, strb_d;
  logic [ICAP_WIDTH-1:0]     data_q, data_d;
  logic                      decouple_q, decouple_d;
  logic                      done_q, done_d;
  logic                      aborted_q, aborted_d;
  logic                      err_q, err_d;

  logic                      fifo_push, fifo_pop, fifo_flush;
  logic                      fifo_full, fifo_empty;
  logic [IN_DATA_WIDTH-1:0]  fifo_dout;
  logic [ICAP_WIDTH-1:0]     word_sel;

  rc_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (IN_DATA_WIDTH)
  ) u_fifo (
    .clk   (AXI_aclk),
    .rst   (AXI_areset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (s_tdata),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // An abort pulse closes the input the same cycle so no beat is taken while flushing.
  assign s_tready  = !fifo_full && (state_q == PRE || state_q == STREAM) &&
                     (beats_left_q != '0) && !abort;
  assign fifo_push = s_tvalid && s_tready;
  assign word_sel  = fifo_dout[int'(word_idx_q) * ICAP_WIDTH +: ICAP_WIDTH];

  always_comb begin
    state_d      = state_q;
    guard_d      = guard_q;
    words_left_d = words_left_q;
    beats_left_d = fifo_push ? beats_left_q - 1'b1 : beats_left_q;
    word_idx_d   = word_idx_q;
    swap_d       = swap_q;
    strb_d       = 1'b0;
    data_d       = data_q;
    decouple_d   = decouple_q;
    done_d       = 1'b0;
    aborted_d    = aborted_q;
    err_d        = err_q;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          swap_d       = bitswap_en;
          aborted_d    = 1'b0;
          words_left_d = bs_length;
          word_idx_d   = '0;
          // ceil(bs_length / R) beats are needed; extra bit avoids overflow.
          beats_left_d = BS_LENGTH_BITS'(({1'b0, bs_length} +
                                          (BS_LENGTH_BITS + 1)'(R - 1)) >> LOG2R);
          if (bs_length == '0) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            err_d      = 1'b0;
            decouple_d = 1'b1;
            guard_d    = GUARD_LESS;
            state_d    = PRE;
          end
        end
      end
      PRE, STREAM: begin
        if (abort) begin
          fifo_flush   = 1'b1;
          aborted_d    = 1'b1;
          beats_left_d = '0;
          guard_d      = GUARD_LESS;
          state_d      = POST;
        end else if (state_q == PRE) begin
          if (guard_q == '0) state_d = STREAM;
          else               guard_d = guard_q - 1'b1;
        end else if (!fifo_empty) begin
          strb_d       = 1'b1;
          data_d       = swap_q ? ICAP_WIDTH'(bitswap_bytes(BITSWAP_MAX_W'(word_sel))) : word_sel;
          words_left_d = words_left_q - 1'b1;
          if (words_left_q == BS_LENGTH_BITS'(1)) begin
            // Last word: pop also discards any unused words of the final beat.
            fifo_pop = 1'b1;
            guard_d  = GUARD_FULL;
            state_d  = POST;
          end else if (word_idx_q == LAST_IDX) begin
            fifo_pop   = 1'b1;
            word_idx_d = '0;
          end else begin
            word_idx_d = word_idx_q + 1'b1;
          end
        end
      end
      POST: begin
        if (guard_q == '0) begin
          decouple_d = 1'b0;
          done_d     = 1'b1;
          state_d    = DONE;
        end else begin
          guard_d = guard_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AXI_aclk or posedge AXI_areset) begin
    if (AXI_areset) begin
      state_q      <= IDLE;
      guard_q      <= '0;
      words_left_q <= '0;
      beats_left_q <= '0;
      word_idx_q   <= '0;
      swap_q       <= 1'b0;
      strb_q       <= 1'b0;
      data_q       <= '0;
      decouple_q   <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      guard_q      <= guard_d;
      words_left_q <= words_left_d;
      beats_left_q <= beats_left_d;
      word_idx_q   <= word_idx_d;
      swap_q       <= swap_d;
      strb_q       <= strb_d;
      data_q       <= data_d;
      decouple_q   <= decouple_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      err_q        <= err_d;
    end
  end

  assign icape2_data_out = data_q;
  assign icape2_strb     = strb_q;
  assign decouple        = decouple_q;
  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign aborted         = aborted_q;
  assign err_length      = err_q;

endmodule

// File: tb/tb_rc_icap_streamer.sv
module tb_rc_icap_streamer;

  logic        AXI_aclk = 1'b0;
  logic        AXI_areset;
  logic        start;
  logic [23:0] bs_length;
  logic        bitswap_en;
  logic        abort;
  logic [63:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] icape2_data_out;
  logic        icape2_strb;
  logic        decouple;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        err_length;

  rc_icap_streamer dut (
    .AXI_aclk        (AXI_aclk),
    .AXI_areset      (AXI_areset),
    .start           (start),
    .bs_length       (bs_length),
    .bitswap_en      (bitswap_en),
    .abort           (abort),
    .s_tdata         (s_tdata),
    .s_tvalid        (s_tvalid),
    .s_tready        (s_tready),
    .icape2_data_out (icape2_data_out),
    .icape2_strb     (icape2_strb),
    .decouple        (decouple),
    .busy            (busy),
    .done            (done),
    .aborted         (aborted),
    .err_length      (err_length)
  );

  always #5 AXI_aclk = ~AXI_aclk;

  int cyc = 0;
  always @(posedge AXI_aclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  logic [63:0] beats [16];
  logic [31:0] words [$];
  int n_acc, n_strb, n_rise, t_start, t_rise, t_fall, t_first, t_last, t_done, t_abort;
  bit fin;

  typedef struct {
    int          len;
    bit          swap;
    logic [63:0] beat;
    int          cnt;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int i);
    return (i < words.size()) ? words[i] : 32'hxxxx_xxxx;
  endfunction

  // Runs one transfer, recording strobed words and event cycles.
  task automatic run(input int len, input bit swap, input int nbeats, input int first_delay,
                     input int gap_after, input int gap_len, input int abort_on,
                     input int reset_on, input int restart_at, input bit abort_with_start);
    int bi = 0;
    int gap = 0;
    int delay = first_delay;
    bit dec_prev = 1'b0;
    bit abort_sent = 1'b0;
    words.delete();
    n_acc = 0; n_strb = 0; n_rise = 0;
    t_rise = -1; t_fall = -1; t_first = -1; t_last = -1; t_done = -1; t_abort = -1;
    fin = 1'b0;
    for (int c = 0; c < 600 && !fin; c++) begin
      s_tvalid   = (bi < nbeats) && (gap == 0) && (delay == 0);
      s_tdata    = (bi < nbeats) ? beats[bi] : 64'h0;
      start      = (c == 0) || (c == restart_at);
      bs_length  = (c == restart_at) ? 24'd0 : 24'(len);
      bitswap_en = swap;
      abort      = (c == 0 && abort_with_start) ||
                   (abort_on > 0 && n_strb == abort_on && !abort_sent);
      if (abort && c != 0) begin
        abort_sent = 1'b1;
        t_abort    = cyc;
      end
      if (c == 0) t_start = cyc;
      @(negedge AXI_aclk);
      if (s_tvalid && s_tready) begin
        bi++;
        n_acc++;
        if (bi == gap_after) gap = gap_len;
      end else if (delay > 0) begin
        delay--;
      end else if (gap > 0) begin
        gap--;
      end
      @(posedge AXI_aclk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      if (icape2_strb) begin
        words.push_back(icape2_data_out);
        if (n_strb == 0) t_first = cyc;
        t_last = cyc;
        n_strb++;
      end
      if (decouple && !dec_prev) begin
        n_rise++;
        t_rise = cyc;
      end
      if (!decouple && dec_prev) t_fall = cyc;
      dec_prev = decouple;
      if (done) begin
        t_done = cyc;
        fin    = 1'b1;
      end
      if (reset_on > 0 && n_strb == reset_on) begin
        #2 AXI_areset = 1'b1;
        #1;
        check("reset outputs", 64'({icape2_strb, decouple, busy, done, aborted, err_length, s_tready}), 64'h0);
        check("reset data", 64'(icape2_data_out), 64'h0);
        fin = 1'b1;
      end
    end
    if (!fin) begin
      n_checks++;
      n_err++;
      $display("FAIL timeout: no done within 600 cycles, len %0d", len);
    end
    s_tvalid = 1'b0;
    repeat (2) begin
      @(posedge AXI_aclk);
      #1;
    end
  endtask

  initial begin
    AXI_areset = 1'b1;
    start = 1'b0; bs_length = '0; bitswap_en = 1'b0; abort = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0;

    // Single-beat transfers. Swap values worked out bit by bit within each byte,
    // e.g. 0x80->0x01, 0x40->0x02, 0x20->0x04, 0x01->0x80.
    vecs[0] = '{len: 2, swap: 1'b1, beat: 64'h00000000_80402001, cnt: 2, w0: 32'h01020480, w1: 32'h00000000};
    vecs[1] = '{len: 2, swap: 1'b0, beat: 64'hDEADBEEF_12345678, cnt: 2, w0: 32'h12345678, w1: 32'hDEADBEEF};
    vecs[2] = '{len: 1, swap: 1'b0, beat: 64'hAAAAAAAA_55555555, cnt: 1, w0: 32'h55555555, w1: 32'h0};
    vecs[3] = '{len: 2, swap: 1'b1, beat: 64'h0F0F0F0F_12345678, cnt: 2, w0: 32'h482C6A1E, w1: 32'hF0F0F0F0};
    vecs[4] = '{len: 1, swap: 1'b1, beat: 64'hFFFFFFFF_00000001, cnt: 1, w0: 32'h00000080, w1: 32'h0};

    repeat (3) @(posedge AXI_aclk);
    #1;
    check("reset state", 64'({icape2_strb, decouple, busy, done, aborted, err_length, s_tready}), 64'h0);
    check("reset data", 64'(icape2_data_out), 64'h0);
    AXI_areset = 1'b0;
    @(posedge AXI_aclk);
    #1;

    // 5 words from 3 beats, 4th beat must not be taken
    beats[0] = 64'h00000002_00000001;
    beats[1] = 64'h00000004_00000003;
    beats[2] = 64'h00000006_00000005;
    beats[3] = 64'h00000008_00000007;
    run(5, 1'b0, 4, 0, 0, 0, 0, 0, -1, 1'b0);
    check("t1 strobes", 64'(n_strb), 64'd5);
    for (int i = 0; i < 5; i++) check($sformatf("t1 word%0d", i), 64'(word_at(i)), 64'(i + 1));
    check("t1 beats accepted", 64'(n_acc), 64'd3);
    check("t1 pre guard >= 8", 64'(t_first - t_rise >= 8), 64'd1);
    check("t1 post guard", 64'(t_fall - t_last), 64'd9);
    check("t1 done", 64'(t_done), 64'(t_fall));
    check("t1 aborted", 64'(aborted), 64'd0);

    foreach (vecs[v]) begin
      beats[0] = vecs[v].beat;
      run(vecs[v].len, vecs[v].swap, 1, 0, 0, 0, 0, 0, -1, 1'b0);
      check($sformatf("vec%0d count", v), 64'(n_strb), 64'(vecs[v].cnt));
      check($sformatf("vec%0d w0", v), 64'(word_at(0)), 64'(vecs[v].w0));
      if (vecs[v].cnt == 2) check($sformatf("vec%0d w1", v), 64'(word_at(1)), 64'(vecs[v].w1));
    end

    // Underrun: beats held back until STREAM, then a 10-cycle gap after beat 2
    for (int b = 0; b < 4; b++) beats[b] = {32'(2*b + 2), 32'(2*b + 1)};
    run(8, 1'b0, 4, 12, 2, 10, 0, 0, -1, 1'b0);
    check("t3 strobes", 64'(n_strb), 64'd8);
    for (int i = 0; i < 8; i++) check($sformatf("t3 word%0d", i), 64'(word_at(i)), 64'(i + 1));
    check("t3 underrun seen", 64'((t_last - t_first + 1 - n_strb) >= 4), 64'd1);
    check("t3 decouple single pulse", 64'(n_rise), 64'd1);
    check("t3 post guard", 64'(t_fall - t_last), 64'd9);

    // Abort on the 3rd strobe of a 16-word run
    for (int b = 0; b < 8; b++) beats[b] = {32'(32'h101 + 2*b), 32'(32'h100 + 2*b)};
    run(16, 1'b0, 8, 0, 0, 0, 3, 0, -1, 1'b0);
    check("t4 strobes", 64'(n_strb), 64'd3);
    check("t4 third word", 64'(word_at(2)), 64'h102);
    check("t4 aborted", 64'(aborted), 64'd1);
    check("t4 decouple drop", 64'(t_fall - t_abort), 64'd9);
    check("t4 done", 64'(t_done), 64'(t_fall));
    beats[0] = 64'h0000000B_0000000A;
    run(2, 1'b0, 1, 0, 0, 0, 0, 0, -1, 1'b0);
    check("t4 flushed w0", 64'(word_at(0)), 64'hA);
    check("t4 flushed w1", 64'(word_at(1)), 64'hB);
    check("t4 aborted cleared", 64'(aborted), 64'd0);

    // Zero length, then a start while busy and start+abort together in IDLE
    run(0, 1'b0, 0, 0, 0, 0, 0, 0, -1, 1'b0);
    check("t5 done latency", 64'(t_done - t_start), 64'd1);
    check("t5 err_length", 64'(err_length), 64'd1);
    check("t5 no decouple", 64'(n_rise), 64'd0);
    check("t5 no strobes", 64'(n_strb), 64'd0);
    beats[0] = 64'h00000022_00000011;
    run(2, 1'b0, 1, 0, 0, 0, 0, 0, 3, 1'b1);
    check("t5 busy start ignored", 64'(n_strb), 64'd2);
    check("t5 busy w1", 64'(word_at(1)), 64'h22);
    check("t5 err cleared", 64'(err_length), 64'd0);
    check("t5 start beats abort", 64'(aborted), 64'd0);

    // Reset mid-STREAM, then a clean transfer
    for (int b = 0; b < 8; b++) beats[b] = {32'(32'h201 + 2*b), 32'(32'h200 + 2*b)};
    run(16, 1'b0, 8, 0, 0, 0, 0, 2, -1, 1'b0);
    AXI_areset = 1'b0;
    @(posedge AXI_aclk);
    #1;
    beats[0] = 64'h00000301_00000300;
    beats[1] = 64'h00000303_00000302;
    run(3, 1'b0, 2, 0, 0, 0, 0, 0, -1, 1'b0);
    check("t6 strobes", 64'(n_strb), 64'd3);
    for (int i = 0; i < 3; i++) check($sformatf("t6 word%0d", i), 64'(word_at(i)), 64'(32'h300 + i));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
